// File: rtl/regfile_scoreboard.sv
// Register file with two write-back ports, same-cycle read bypass and a
// per-register pending-load scoreboard for issue-stage hazard detection.
module regfile_scoreboard #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 4,
  parameter bit          ZERO_R0 = 1'b1,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      rd_addr_a,
  output logic [DATA_W-1:0]      rd_data_a,
  output logic                   rd_busy_a,
  input  logic [ADDR_W-1:0]      rd_addr_b,
  output logic [DATA_W-1:0]      rd_data_b,
  output logic                   rd_busy_b,
  input  logic                   wa_en,
  input  logic [ADDR_W-1:0]      wa_addr,
  input  logic [DATA_W-1:0]      wa_data,
  input  logic                   wb_en,
  input  logic [ADDR_W-1:0]      wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic                   issue_en,
  input  logic [ADDR_W-1:0]      issue_addr,
  output logic                   issue_stall,
  output logic [2**ADDR_W-1:0]   busy_vec,
  output logic                   err_waw
);

  localparam int unsigned NUM_REGS = 2**ADDR_W;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] busy_next;

  logic wa_zero, wb_zero, issue_zero;
  logic wa_ok, wb_ok, wb_store, issue_ok, waw_hit;

  assign wa_zero    = ZERO_R0 && (wa_addr == '0);
  assign wb_zero    = ZERO_R0 && (wb_addr == '0);
  assign issue_zero = ZERO_R0 && (issue_addr == '0);

  assign wa_ok    = wa_en && !wa_zero;
  assign wb_ok    = wb_en && !wb_zero;
  // Port A wins a same-address collision; port B's data is dropped.
  assign wb_store = wb_ok && !(wa_ok && (wa_addr == wb_addr));

  // ---------------------------------------------------------------------
  // Register array
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '{default: '0};
    end else begin
      if (wa_ok)    regs[wa_addr] <= wa_data;
      if (wb_store) regs[wb_addr] <= wb_data;
    end
  end

  // ---------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------
  always_comb begin
    rd_data_a = '0;
    rd_busy_a = 1'b0;
    if (rst_n && !(ZERO_R0 && (rd_addr_a == '0))) begin
      if (BYPASS && wa_en && (wa_addr == rd_addr_a))
        rd_data_a = wa_data;
      else if (BYPASS && wb_en && (wb_addr == rd_addr_a))
        rd_data_a = wb_data;
      else
        rd_data_a = regs[rd_addr_a];
      rd_busy_a = busy_vec[rd_addr_a] &&
                  !(BYPASS && wb_en && (wb_addr == rd_addr_a));
    end
  end

  always_comb begin
    rd_data_b = '0;
    rd_busy_b = 1'b0;
    if (rst_n && !(ZERO_R0 && (rd_addr_b == '0))) begin
      if (BYPASS && wa_en && (wa_addr == rd_addr_b))
        rd_data_b = wa_data;
      else if (BYPASS && wb_en && (wb_addr == rd_addr_b))
        rd_data_b = wb_data;
      else
        rd_data_b = regs[rd_addr_b];
      rd_busy_b = busy_vec[rd_addr_b] &&
                  !(BYPASS && wb_en && (wb_addr == rd_addr_b));
    end
  end

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  // A load completing this cycle frees its register for immediate re-issue.
  assign issue_stall = rst_n && issue_en && !issue_zero &&
                       busy_vec[issue_addr] &&
                       !(wb_en && (wb_addr == issue_addr));

  assign issue_ok = issue_en && !issue_stall && !issue_zero;
  assign waw_hit  = wa_en && !wa_zero && busy_vec[wa_addr];

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_ok) set_vec = NUM_REGS'(1) << issue_addr;
    if (wb_en)    clr_vec = NUM_REGS'(1) << wb_addr;
    // Set takes precedence over clear on the same register.
    busy_next = set_vec | (busy_vec & ~clr_vec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec <= '0;
      err_waw  <= 1'b0;
    end else begin
      busy_vec <= busy_next;
      if (waw_hit) err_waw <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default, no-bypass and a
// 64-bit/32-entry/no-zero-register configuration.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Shared stimulus for the default and the no-bypass instances
  logic [3:0]  ra, rb, wa_addr, wb_addr, issue_addr;
  logic [31:0] wa_data, wb_data;
  logic        wa_en, wb_en, issue_en;
  logic [31:0] da, db, nda, ndb;
  logic        ba, bb, nba, nbb, stall, nstall, err, nerr;
  logic [15:0] busy, nbusy;

  regfile_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_a(ra), .rd_data_a(da), .rd_busy_a(ba),
    .rd_addr_b(rb), .rd_data_b(db), .rd_busy_b(bb),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .issue_stall(stall),
    .busy_vec(busy), .err_waw(err)
  );

  regfile_scoreboard #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_a(ra), .rd_data_a(nda), .rd_busy_a(nba),
    .rd_addr_b(rb), .rd_data_b(ndb), .rd_busy_b(nbb),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .issue_stall(nstall),
    .busy_vec(nbusy), .err_waw(nerr)
  );

  // Wide configuration
  logic [4:0]  s_ra, s_rb, s_wa_addr, s_wb_addr, s_issue_addr;
  logic [63:0] s_wa_data, s_wb_data, s_da, s_db;
  logic        s_wa_en, s_wb_en, s_issue_en, s_ba, s_bb, s_stall, s_err;
  logic [31:0] s_busy;

  regfile_scoreboard #(.DATA_W(64), .ADDR_W(5), .ZERO_R0(1'b0), .BYPASS(1'b1)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_a(s_ra), .rd_data_a(s_da), .rd_busy_a(s_ba),
    .rd_addr_b(s_rb), .rd_data_b(s_db), .rd_busy_b(s_bb),
    .wa_en(s_wa_en), .wa_addr(s_wa_addr), .wa_data(s_wa_data),
    .wb_en(s_wb_en), .wb_addr(s_wb_addr), .wb_data(s_wb_data),
    .issue_en(s_issue_en), .issue_addr(s_issue_addr), .issue_stall(s_stall),
    .busy_vec(s_busy), .err_waw(s_err)
  );

  typedef struct {
    logic        wa_en;  logic [3:0] wa_addr;  logic [31:0] wa_data;
    logic        wb_en;  logic [3:0] wb_addr;  logic [31:0] wb_data;
    logic        is_en;  logic [3:0] is_addr;
    logic [3:0]  ra;     logic [3:0] rb;
    logic [31:0] e_da;   logic       e_ba;
    logic [31:0] e_db;   logic       e_bb;
    logic        e_stall;
    logic [15:0] e_busy; logic       e_err;
    logic [31:0] e_nda;  logic       e_nba;
  } vec_t;

  vec_t vecs[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(
    input logic wae, input logic [3:0] waa, input logic [31:0] wad,
    input logic wbe, input logic [3:0] wba, input logic [31:0] wbd,
    input logic ie,  input logic [3:0] ia,
    input logic [3:0] a, input logic [3:0] b,
    input logic [31:0] xda, input logic xba, input logic [31:0] xdb, input logic xbb,
    input logic xst, input logic [15:0] xbusy, input logic xerr,
    input logic [31:0] xnda, input logic xnba);
    vec_t v;
    v.wa_en = wae; v.wa_addr = waa; v.wa_data = wad;
    v.wb_en = wbe; v.wb_addr = wba; v.wb_data = wbd;
    v.is_en = ie;  v.is_addr = ia;  v.ra = a; v.rb = b;
    v.e_da = xda;  v.e_ba = xba;    v.e_db = xdb; v.e_bb = xbb;
    v.e_stall = xst; v.e_busy = xbusy; v.e_err = xerr;
    v.e_nda = xnda; v.e_nba = xnba;
    vecs.push_back(v);
  endtask

  task automatic idle_main();
    wa_en = 0; wa_addr = 0; wa_data = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0;
    issue_en = 0; issue_addr = 0; ra = 0; rb = 0;
  endtask

  task automatic idle_wide();
    s_wa_en = 0; s_wa_addr = 0; s_wa_data = 0;
    s_wb_en = 0; s_wb_addr = 0; s_wb_data = 0;
    s_issue_en = 0; s_issue_addr = 0; s_ra = 0; s_rb = 0;
  endtask

  initial begin
    // Expectations reflect state before the edge that ends each vector.
    //   wa          wb            issue   ra  rb   da        ba db        bb st busy    err nda       nba
    add(0,0,0,       0,0,0,        0,0,    0, 15, 0,         0, 0,         0, 0, 16'h0,  0, 0,         0);
    add(1,5,32'hDEADBEEF, 0,0,0,   0,0,    5, 5,  32'hDEADBEEF,0,32'hDEADBEEF,0,0,16'h0, 0, 0,         0);
    add(0,0,0,       0,0,0,        0,0,    5, 0,  32'hDEADBEEF,0,0,        0, 0, 16'h0,  0, 32'hDEADBEEF,0);
    add(1,0,32'h55,  0,0,0,        0,0,    0, 0,  0,         0, 0,         0, 0, 16'h0,  0, 0,         0);
    add(0,0,0,       0,0,0,        0,0,    0, 5,  0,         0, 32'hDEADBEEF,0,0,16'h0,  0, 0,         0);
    add(0,0,0,       0,0,0,        1,7,    7, 0,  0,         0, 0,         0, 0, 16'h0,  0, 0,         0);
    add(0,0,0,       0,0,0,        1,7,    7, 7,  0,         1, 0,         1, 1, 16'h80, 0, 0,         1);
    add(0,0,0,       1,7,32'h1234, 0,0,    7, 5,  32'h1234,  0, 32'hDEADBEEF,0,0,16'h80, 0, 0,         1);
    add(0,0,0,       0,0,0,        0,0,    7, 0,  32'h1234,  0, 0,         0, 0, 16'h0,  0, 32'h1234,  0);
    add(0,0,0,       0,0,0,        1,7,    7, 0,  32'h1234,  0, 0,         0, 0, 16'h0,  0, 32'h1234,  0);
    add(0,0,0,       1,7,32'h5678, 1,7,    7, 0,  32'h5678,  0, 0,         0, 0, 16'h80, 0, 32'h1234,  1);
    add(0,0,0,       0,0,0,        0,0,    7, 7,  32'h5678,  1, 32'h5678,  1, 0, 16'h80, 0, 32'h5678,  1);
    add(0,0,0,       0,0,0,        1,3,    3, 0,  0,         0, 0,         0, 0, 16'h80, 0, 0,         0);
    add(1,3,32'hA,   1,3,32'hB,    0,0,    3, 3,  32'hA,     0, 32'hA,     0, 0, 16'h88, 0, 0,         1);
    add(0,0,0,       0,0,0,        0,0,    3, 7,  32'hA,     0, 32'h5678,  1, 0, 16'h80, 1, 32'hA,     0);
    add(1,7,32'h99,  0,0,0,        0,0,    7, 0,  32'h99,    1, 0,         0, 0, 16'h80, 1, 32'h5678,  1);
    add(0,0,0,       0,0,0,        0,0,    7, 0,  32'h99,    1, 0,         0, 0, 16'h80, 1, 32'h99,    1);
    add(0,0,0,       1,9,32'h77,   0,0,    9, 0,  32'h77,    0, 0,         0, 0, 16'h80, 1, 0,         0);
    add(0,0,0,       0,0,0,        1,0,    9, 0,  32'h77,    0, 0,         0, 0, 16'h80, 1, 32'h77,    0);
    add(0,0,0,       0,0,0,        0,0,    0, 0,  0,         0, 0,         0, 0, 16'h80, 1, 0,         0);
    add(0,0,0,       1,7,32'h42,   0,0,    7, 9,  32'h42,    0, 32'h77,    0, 0, 16'h80, 1, 32'h99,    1);
    add(0,0,0,       0,0,0,        0,0,    7, 9,  32'h42,    0, 32'h77,    0, 0, 16'h0,  1, 32'h42,    0);

    // Reset: outputs forced low even with a live write on the bus
    idle_main(); idle_wide();
    rst_n = 1'b0;
    wa_en = 1; wa_addr = 5; wa_data = 32'h1111; ra = 5; rb = 5;
    #1;
    chk("reset_rd_data_a", da, 0);
    chk("reset_rd_busy_a", ba, 0);
    chk("reset_busy_vec", busy, 0);
    chk("reset_err_waw", err, 0);
    idle_main();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ra = 4'(i); rb = 4'(15 - i);
      #1;
      chk($sformatf("post_reset_rd_a[%0d]", i), da, 0);
      chk($sformatf("post_reset_rd_b[%0d]", 15 - i), db, 0);
    end
    chk("post_reset_busy_vec", busy, 0);
    chk("post_reset_err_waw", err, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      wa_en = vecs[i].wa_en; wa_addr = vecs[i].wa_addr; wa_data = vecs[i].wa_data;
      wb_en = vecs[i].wb_en; wb_addr = vecs[i].wb_addr; wb_data = vecs[i].wb_data;
      issue_en = vecs[i].is_en; issue_addr = vecs[i].is_addr;
      ra = vecs[i].ra; rb = vecs[i].rb;
      #1;
      chk($sformatf("v%0d rd_data_a", i), da, vecs[i].e_da);
      chk($sformatf("v%0d rd_busy_a", i), ba, vecs[i].e_ba);
      chk($sformatf("v%0d rd_data_b", i), db, vecs[i].e_db);
      chk($sformatf("v%0d rd_busy_b", i), bb, vecs[i].e_bb);
      chk($sformatf("v%0d issue_stall", i), stall, vecs[i].e_stall);
      chk($sformatf("v%0d busy_vec", i), busy, vecs[i].e_busy);
      chk($sformatf("v%0d err_waw", i), err, vecs[i].e_err);
      chk($sformatf("v%0d nobyp rd_data_a", i), nda, vecs[i].e_nda);
      chk($sformatf("v%0d nobyp rd_busy_a", i), nba, vecs[i].e_nba);
    end

    // Mid-run reset: pending bit and sticky error both set beforehand
    @(negedge clk);
    idle_main();
    issue_en = 1; issue_addr = 4;
    wa_en = 1; wa_addr = 7; wa_data = 32'h3;
    @(negedge clk);
    idle_main(); ra = 7;
    #1;
    chk("pre_rst busy_vec", busy, 16'h0010);
    chk("pre_rst rd_data_a", da, 32'h3);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst rd_data_a", da, 0);
    chk("mid_rst busy_vec", busy, 0);
    chk("mid_rst err_waw", err, 0);
    chk("mid_rst nobyp err_waw", nerr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ra = 3; rb = 9;
    #1;
    chk("after_rst rd_data_a", da, 0);
    chk("after_rst rd_data_b", db, 0);

    // Wide configuration: register 0 is a normal register
    @(negedge clk);
    s_wa_en = 1; s_wa_addr = 0; s_wa_data = 64'hFFFF_FFFF_FFFF_FFFF; s_ra = 0;
    #1;
    chk("wide bypass r0", s_da, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    idle_wide();
    s_wa_en = 1; s_wa_addr = 31; s_wa_data = 64'h0123_4567_89AB_CDEF;
    s_issue_en = 1; s_issue_addr = 0; s_ra = 0;
    #1;
    chk("wide r0 stored", s_da, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wide issue r0 stall", s_stall, 0);
    @(negedge clk);
    idle_wide();
    s_issue_en = 1; s_issue_addr = 0; s_ra = 0; s_rb = 31;
    #1;
    chk("wide busy_vec r0", s_busy, 32'h1);
    chk("wide rd_busy_a r0", s_ba, 1);
    chk("wide reissue r0 stall", s_stall, 1);
    chk("wide r31", s_db, 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    idle_wide();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised register file with two write-back ports, same-cycle write-to-read bypass and a per-register pending scoreboard.
- Sits between the decode/issue stage and the two write-back sources: the single-cycle ALU (port A) and the multi-cycle load/memory unit (port B).
- Generalises the 16x32 register file in data width and depth, with an optional hardwired-zero register.
- Lets the issue stage stall on read-after-write and write-after-write hazards against outstanding loads.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 4, register address width; NUM_REGS = 2**ADDR_W
ZERO_R0, 1, 1: register 0 reads as zero, is never written and is never marked pending
BYPASS, 1, 1: same-cycle write data is forwarded to the read ports

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rd_addr_a  in  ADDR_W  read port A address
rd_data_a  out  DATA_W  read port A data (combinational)
rd_busy_a  out  1  register at rd_addr_a has an outstanding load
rd_addr_b  in  ADDR_W  read port B address
rd_data_b  out  DATA_W  read port B data (combinational)
rd_busy_b  out  1  register at rd_addr_b has an outstanding load
wa_en  in  1  ALU write enable (higher priority)
wa_addr  in  ADDR_W  ALU write address
wa_data  in  DATA_W  ALU write data
wb_en  in  1  load write enable; clears the pending bit
wb_addr  in  ADDR_W  load write address
wb_data  in  DATA_W  load write data
issue_en  in  1  request to mark a destination register pending
issue_addr  in  ADDR_W  destination register of the issued load
issue_stall  out  1  issue refused this cycle (combinational)
busy_vec  out  NUM_REGS  pending bit per register (registered)
err_waw  out  1  sticky: ALU wrote a register with an outstanding load

Behaviour:
- Reset (asynchronous, rst_n low):
  - All registers = 0, busy_vec = 0, err_waw = 0.
  - Outputs while in reset: rd_data_* = 0, rd_busy_* = 0, issue_stall = 0.
  - Reset mid-operation discards all pending bits and in-flight state.
- Writes occur on the rising edge.
  - Both ports to the same address: wa_data is stored and wb_data is dropped.
  - wb_en to that address still clears the pending bit.
  - With ZERO_R0 = 1, writes to address 0 are ignored.
- Reads are combinational from array state.
  - ZERO_R0 = 1 and address 0: output 0, busy 0.
  - BYPASS = 1: a matching enabled write this cycle is forwarded (wa over wb, else array). Latency 0.
  - BYPASS = 0: written data is visible the cycle after the write edge.
- rd_busy_x = busy_vec[rd_addr_x], except it reads 0 when BYPASS = 1 and wb_en && wb_addr == rd_addr_x this cycle (the load result is being forwarded).
- Scoreboard, per register r (pending bit update on each edge):
  - Set when issue_en && !issue_stall && issue_addr == r.
  - Else cleared when wb_en && wb_addr == r.
  - Else held.
  - Set wins over clear in the same cycle.
  - Register 0 is never set when ZERO_R0 = 1.
- issue_stall = issue_en && busy_vec[issue_addr] && !(wb_en && wb_addr == issue_addr).
  - A load completing in the same cycle frees the register for re-issue immediately.
  - issue_stall = 0 for address 0 when ZERO_R0 = 1.
- err_waw is set on the edge where wa_en && busy_vec[wa_addr] (address nonzero if ZERO_R0 = 1), and holds until reset.
  - The wa write itself still happens.
  - wa writes never clear pending bits.
- wb_en to a register that is not pending: data is written, no error, busy stays 0.
- All address widths are exact; no out-of-range addresses exist since NUM_REGS = 2**ADDR_W.

Test Plan:
- Reset then read all 16 addresses:
  - rd_data = 0, busy_vec = 0, err_waw = 0.
  - Assert rst_n low mid-run after writes: all of the above return to 0 immediately.
- wa_en=1, wa_addr=5, wa_data=0xDEADBEEF with rd_addr_a=5 in the same cycle:
  - rd_data_a = 0xDEADBEEF in that cycle (BYPASS = 1) and on following cycles.
  - Write to addr 0: rd_data = 0.
- Issue addr 7:
  - busy_vec[7] = 1 next cycle; rd_busy_a = 1 for rd_addr_a = 7.
  - A second issue to 7 gives issue_stall = 1.
  - wb_en, wb_addr=7, wb_data=0x1234 gives rd_data_a = 0x1234 and rd_busy_a = 0 that cycle; busy_vec[7] = 0 after the edge.
- Same cycle wb to 7 (pending) and issue to 7:
  - issue_stall = 0 and the register is stored with wb_data.
  - busy_vec[7] remains 1.
- wa and wb both to addr 3 (pending), wa_data=0xA, wb_data=0xB:
  - Register 3 = 0xA, busy_vec[3] = 0, err_waw = 1 and stays 1.
- Parameter sweep DATA_W=64, ADDR_W=5, ZERO_R0=0:
  - Write 0xFFFF_FFFF_FFFF_FFFF to addr 0 reads back the value.
  - Issue addr 0 sets busy_vec[0].
